// File: rtl/tile_pkg.sv
// Shared types and constants for the tile nibble serializer.
//   TILE_WORDS / WORD_NIBS : default tile geometry (words per tile, nibbles per word)
//   NIB_W                  : nibble width
//   TILE_NIBS / TILE_W     : nibbles per tile and flattened tile width
//   tile_t                 : packed tile (word, nibble, bit)
//   ser_state_e            : serializer FSM states
package tile_pkg;

    localparam int unsigned TILE_WORDS = 2;
    localparam int unsigned WORD_NIBS  = 4;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned TILE_NIBS  = TILE_WORDS * WORD_NIBS;
    localparam int unsigned TILE_W     = TILE_NIBS * NIB_W;

    typedef logic [TILE_WORDS-1:0][WORD_NIBS-1:0][NIB_W-1:0] tile_t;

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_e;

endpackage

// File: rtl/tile_xz_scrub.sv
// Combinational X/Z scrubber for one nibble. Built only when TILE_XZ_SCRUB_EN is defined.
//   nibble : raw nibble from the tile buffer
//   clean  : nibble with any X/Z content replaced by zero
//   xz     : raw nibble held at least one X/Z bit
`ifdef TILE_XZ_SCRUB_EN
module tile_xz_scrub
    import tile_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [NIB_W-1:0] clean,
    output logic             xz
);

    always_comb begin
        clean = nibble;
        xz    = 1'b0;
        // Reduction XOR goes X if any bit is X or Z.
        if ((^nibble) === 1'bx) begin
            clean = '0;
            xz    = 1'b1;
        end
    end

endmodule
`endif

// File: rtl/tile_nibble_serializer.sv
// Captures one tile per in_valid/in_ready handshake and streams it out MSB nibble first.
// Configuration macro: TILE_XZ_SCRUB_EN (scrub X/Z nibbles to zero and flag them on out_xz).
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : tile input handshake; in_tile is the flattened tile (word 0 in MSBs)
//   out_valid/out_ready   : nibble output handshake
//   out_nibble, out_idx   : current nibble and its position in the tile (0 = first)
//   out_last              : current nibble is the final one of the tile
//   out_xz                : current nibble carried X/Z bits (scrub build only, else 0)
//   frame_cnt             : tiles fully emitted since reset, wraps
module tile_nibble_serializer
    import tile_pkg::*;
#(
    parameter int unsigned NWORDS = TILE_WORDS,
    parameter int unsigned NIBS   = WORD_NIBS,
    parameter int unsigned CNT_W  = 8,
    localparam int unsigned N_NIBS = NWORDS * NIBS,
    localparam int unsigned IN_W   = N_NIBS * NIB_W,
    localparam int unsigned IDX_W  = $clog2(N_NIBS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_tile,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NIB_W-1:0] out_nibble,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_xz,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIBS - 1);

    ser_state_e       state_q;
    logic [IN_W-1:0]  buf_q;
    logic [IDX_W-1:0] idx_q;
    logic [NIB_W-1:0] nib_q;
    logic             xz_q;
    logic [CNT_W-1:0] cnt_q;

    logic             load;
    logic [NIB_W-1:0] raw_next;
    logic [NIB_W-1:0] clean_next;
    logic             xz_next;

    assign out_valid  = (state_q == SEND);
    assign out_last   = (state_q == SEND) && (idx_q == LAST_IDX);
    assign in_ready   = !rst && ((state_q == IDLE) || ((state_q == SEND) && out_ready && out_last));
    assign load       = in_valid && in_ready;
    assign out_nibble = nib_q;
    assign out_idx    = idx_q;
    assign out_xz     = xz_q;
    assign frame_cnt  = cnt_q;

    // The buffer shifts left on each accepted nibble, so the next nibble to show is always
    // the one just below the top of the buffer; a fresh tile shows its own top nibble.
    assign raw_next = load ? in_tile[IN_W-1 -: NIB_W] : buf_q[IN_W-NIB_W-1 -: NIB_W];

`ifdef TILE_XZ_SCRUB_EN
    tile_xz_scrub u_scrub (
        .nibble (raw_next),
        .clean  (clean_next),
        .xz     (xz_next)
    );
`else
    assign clean_next = raw_next;
    assign xz_next    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            nib_q   <= '0;
            xz_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        buf_q   <= in_tile;
                        idx_q   <= '0;
                        nib_q   <= clean_next;
                        xz_q    <= xz_next;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (out_last) begin
                            cnt_q <= cnt_q + 1'b1;
                            if (load) begin
                                // Next tile follows with no bubble.
                                buf_q <= in_tile;
                                idx_q <= '0;
                                nib_q <= clean_next;
                                xz_q  <= xz_next;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            buf_q <= {buf_q[IN_W-NIB_W-1:0], {NIB_W{1'b0}}};
                            idx_q <= idx_q + 1'b1;
                            nib_q <= clean_next;
                            xz_q  <= xz_next;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_nibble_serializer.sv
// Directed self-checking bench for tile_nibble_serializer (default 2x4 nibble tile, 8-bit counter).
module tb_tile_nibble_serializer;
    import tile_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [TILE_W-1:0] in_tile;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_nibble;
    logic [2:0]        out_idx;
    logic              out_last;
    logic              out_xz;
    logic [7:0]        frame_cnt;

    int total;
    int passed;

    tile_nibble_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_tile    (in_tile),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_nibble (out_nibble),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_xz     (out_xz),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All stimulus changes and all sampling happen at the falling edge.
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_tile = '0; out_ready = 1'b0;
        #2;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready act=%b exp=0", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid act=%b exp=0", out_valid); else passed++;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk); @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL idle_out_valid act=%b exp=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready act=%b exp=1", in_ready); else passed++;
        total++; if (frame_cnt !== 8'd0) $display("FAIL idle_frame_cnt act=%0d exp=0", frame_cnt); else passed++;
        total++; if (out_nibble !== 4'h0 || out_idx !== 3'd0 || out_last !== 1'b0 || out_xz !== 1'b0)
            $display("FAIL idle_outputs act=%h/%0d/%b/%b exp=0/0/0/0", out_nibble, out_idx, out_last, out_xz);
        else passed++;
    endtask

    task automatic test_single();
        logic [31:0] t;
        t = 32'h1234_ABCD;
        in_tile = t; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_tile = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) begin
            total++; if (out_valid !== 1'b1) $display("FAIL single_valid[%0d] act=%b exp=1", i, out_valid); else passed++;
            total++; if (out_nibble !== t[31-4*i -: 4])
                $display("FAIL single_nibble[%0d] act=%h exp=%h", i, out_nibble, t[31-4*i -: 4]);
            else passed++;
            total++; if (out_idx !== 3'(i)) $display("FAIL single_idx[%0d] act=%0d exp=%0d", i, out_idx, i); else passed++;
            total++; if (out_last !== (i == 7)) $display("FAIL single_last[%0d] act=%b exp=%b", i, out_last, (i == 7)); else passed++;
            @(negedge clk);
        end
        total++; if (out_valid !== 1'b0) $display("FAIL single_end_valid act=%b exp=0", out_valid); else passed++;
        total++; if (frame_cnt !== 8'd1) $display("FAIL single_frame_cnt act=%0d exp=1", frame_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] t;
        t = 64'h0F1E_2D3C_89AB_CDEF;
        in_tile = t[63:32]; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d] act=%b exp=1", i, out_valid); else passed++;
            total++; if (out_nibble !== t[63-4*i -: 4])
                $display("FAIL b2b_nibble[%0d] act=%h exp=%h", i, out_nibble, t[63-4*i -: 4]);
            else passed++;
            if (i == 7) begin
                total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready act=%b exp=1", in_ready); else passed++;
                in_tile = t[31:0];
            end
            if (i == 15) in_valid = 1'b0;
            @(negedge clk);
        end
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_end_valid act=%b exp=0", out_valid); else passed++;
        total++; if (frame_cnt !== 8'd3) $display("FAIL b2b_frame_cnt act=%0d exp=3", frame_cnt); else passed++;
    endtask

    task automatic test_stall();
        logic [31:0] t;
        int k;
        int cyc;
        t = 32'h5A3C_96E1;
        in_tile = t; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0; cyc = 0;
        while (k < 8 && cyc < 40) begin
            total++; if (out_valid !== 1'b1 || out_nibble !== t[31-4*k -: 4] || out_idx !== 3'(k))
                $display("FAIL stall_hold[cyc %0d] act=%b/%h/%0d exp=1/%h/%0d",
                         cyc, out_valid, out_nibble, out_idx, t[31-4*k -: 4], k);
            else passed++;
            if (k == 7 && out_ready == 1'b0) begin
                total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready act=%b exp=0", in_ready); else passed++;
            end
            out_ready = (cyc % 2 == 1);
            if (out_ready) k++;
            cyc++;
            @(negedge clk);
        end
        total++; if (k != 8) $display("FAIL stall_timeout act=%0d exp=8", k); else passed++;
        out_ready = 1'b1;
        total++; if (out_valid !== 1'b0) $display("FAIL stall_end_valid act=%b exp=0", out_valid); else passed++;
        total++; if (frame_cnt !== 8'd4) $display("FAIL stall_frame_cnt act=%0d exp=4", frame_cnt); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] t;
        t = 32'hFEDC_BA98;
        in_tile = t; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        total++; if (out_idx !== 3'd3 || out_nibble !== 4'hC)
            $display("FAIL rstmid_pre act=%0d/%h exp=3/c", out_idx, out_nibble);
        else passed++;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid act=%b exp=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL rstmid_in_ready act=%b exp=0", in_ready); else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || frame_cnt !== 8'd0)
            $display("FAIL rstmid_after act=%b/%0d exp=0/0", out_valid, frame_cnt);
        else passed++;
        t = 32'h0246_8ACE;
        in_tile = t; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++; if (out_valid !== 1'b1 || out_idx !== 3'(i) || out_nibble !== t[31-4*i -: 4])
                $display("FAIL rstmid_next[%0d] act=%b/%0d/%h exp=1/%0d/%h",
                         i, out_valid, out_idx, out_nibble, i, t[31-4*i -: 4]);
            else passed++;
            @(negedge clk);
        end
        total++; if (frame_cnt !== 8'd1) $display("FAIL rstmid_frame_cnt act=%0d exp=1", frame_cnt); else passed++;
    endtask

    task automatic test_xz();
        logic [31:0] t;
        t = {4'b1x0z, 28'h123_4567};
        in_tile = t; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
`ifdef TILE_XZ_SCRUB_EN
        total++; if (out_nibble !== 4'h0 || out_xz !== 1'b1)
            $display("FAIL xz_scrub act=%b/%b exp=0000/1", out_nibble, out_xz);
        else passed++;
`else
        // Only the known bits are compared; the simulator may not keep X/Z.
        total++; if (out_nibble[3] !== 1'b1 || out_nibble[1] !== 1'b0 || out_xz !== 1'b0)
            $display("FAIL xz_pass act=%b/%b exp=1?0?/0", out_nibble, out_xz);
        else passed++;
`endif
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_nibble !== 4'h1 || out_xz !== 1'b0)
            $display("FAIL xz_clean act=%h/%b exp=1/0", out_nibble, out_xz);
        else passed++;
        for (int i = 0; i < 7; i++) @(negedge clk);
        total++; if (out_valid !== 1'b0 || frame_cnt !== 8'd2)
            $display("FAIL xz_end act=%b/%0d exp=0/2", out_valid, frame_cnt);
        else passed++;
    endtask

    initial begin
        total = 0;
        passed = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_xz();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
